// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared fetch-sequencer state and next-PC select encodings.
package pc_sequencer_pkg;
   typedef enum logic {LOAD, RUN} state_t;
   typedef enum logic [2:0] {SEL_HOLD, SEL_BOOT, SEL_EXC, SEL_REDIR, SEL_RAS, SEL_SEQ} sel_t;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int ADDR_W = 32,
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);
   localparam int PW = $clog2(DEPTH);
   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0] ptr, wr_ptr;
   logic [PW:0] depth;
   logic do_pop;
   assign do_pop = pop && depth != '0;
   assign wr_ptr = do_pop ? ptr : ptr + 1'b1;
   assign top = mem[ptr];
   assign empty = depth == '0;
   assign full = depth == (PW+1)'(DEPTH);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ptr <= '0;
         depth <= '0;
      end else if (flush) depth <= '0;
      else if (push != do_pop) begin
         ptr <= push ? ptr + 1'b1 : ptr - 1'b1;
         depth <= push ? (full ? depth : depth + 1'b1) : depth - 1'b1;
      end
   // Pop-then-push rewrites the current top in place, so depth is unchanged.
   always_ff @(posedge clock)
      if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with boot load, exception/redirect priority,
// stall hold and return-address-stack prediction.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int INC = 4,
   parameter int RAS_DEPTH = 4,
   parameter int ALIGN_BITS = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] starting_addr,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              exc_valid,
   input  logic [ADDR_W-1:0] exc_vector,
   input  logic              call_push,
   input  logic              ret_pop,
   output logic [ADDR_W-1:0] cur_count,
   output logic              pc_valid,
   output logic              misaligned,
   output logic              ras_empty,
   output logic              ras_full
);
   state_t state;
   sel_t sel;
   logic [ADDR_W-1:0] next_pc, seq_pc, ras_top;
   logic advance;
   assign seq_pc = cur_count + ADDR_W'(INC);
   assign advance = state == RUN && !exc_valid && !redirect_valid && !stall;
   always_comb begin
      sel = state == LOAD ? SEL_BOOT :
            exc_valid ? SEL_EXC :
            redirect_valid ? SEL_REDIR :
            stall ? SEL_HOLD :
            (ret_pop && !ras_empty) ? SEL_RAS : SEL_SEQ;
      next_pc = sel == SEL_BOOT ? starting_addr :
                sel == SEL_EXC ? exc_vector :
                sel == SEL_REDIR ? redirect_addr :
                sel == SEL_HOLD ? cur_count :
                sel == SEL_RAS ? ras_top : seq_pc;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= LOAD;
         cur_count <= '0;
         pc_valid <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state <= RUN;
         cur_count <= next_pc;
         pc_valid <= 1'b1;
         misaligned <= |next_pc[ALIGN_BITS-1:0];
      end
   ras_stack #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clock(clock),
      .reset(reset),
      .push(advance && call_push),
      .pop(advance && ret_pop),
      .flush(state == RUN && exc_valid),
      .push_data(seq_pc),
      .top(ras_top),
      .empty(ras_empty),
      .full(ras_full)
   );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, randomized run against a queue-based
// model, and an asynchronous mid-run reset sequence.
module tb_pc_sequencer;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [31:0] starting_addr = 32'h0040_0000;
   logic stall = 1'b0, redirect_valid = 1'b0, exc_valid = 1'b0, call_push = 1'b0, ret_pop = 1'b0;
   logic [31:0] redirect_addr = '0, exc_vector = '0;
   logic [31:0] cur_count;
   logic pc_valid, misaligned, ras_empty, ras_full;
   int vectors = 0, miscompares = 0;

   pc_sequencer dut (
      .clock(clock), .reset(reset), .starting_addr(starting_addr), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .exc_valid(exc_valid), .exc_vector(exc_vector), .call_push(call_push),
      .ret_pop(ret_pop), .cur_count(cur_count), .pc_valid(pc_valid),
      .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic st, rv;
      logic [31:0] ra;
      logic ev;
      logic [31:0] ea;
      logic cp, rp;
      logic [31:0] pc;
      logic mis, emp, ful;
   } vec_t;
   vec_t tv[$];

   logic [31:0] m_pc;
   logic m_run;
   logic [31:0] m_ras[$];

   function automatic vec_t v(logic st, logic rv, logic [31:0] ra, logic ev, logic [31:0] ea,
                              logic cp, logic rp, logic [31:0] pc, logic mis, logic emp, logic ful);
      vec_t r;
      r.st = st; r.rv = rv; r.ra = ra; r.ev = ev; r.ea = ea; r.cp = cp; r.rp = rp;
      r.pc = pc; r.mis = mis; r.emp = emp; r.ful = ful;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc = '0;
      m_run = 1'b0;
      m_ras.delete();
   endfunction

   function automatic void model_step();
      logic [31:0] nxt;
      if (!m_run) begin
         m_pc = starting_addr;
         m_run = 1'b1;
      end else if (exc_valid) begin
         m_pc = exc_vector;
         m_ras.delete();
      end else if (redirect_valid) m_pc = redirect_addr;
      else if (!stall) begin
         nxt = m_pc + 32'd4;
         if (ret_pop && m_ras.size() > 0) nxt = m_ras.pop_back();
         if (call_push) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
         end
         m_pc = nxt;
      end
   endfunction

   task automatic drive(logic st, logic rv, logic [31:0] ra, logic ev, logic [31:0] ea, logic cp, logic rp);
      stall = st; redirect_valid = rv; redirect_addr = ra;
      exc_valid = ev; exc_vector = ea; call_push = cp; ret_pop = rp;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (!reset) model_step();
   endtask

   task automatic chk_model(string tag);
      chk({tag, " pc"}, cur_count, m_pc);
      chk({tag, " valid"}, {31'b0, pc_valid}, {31'b0, m_run});
      chk({tag, " mis"}, {31'b0, misaligned}, {31'b0, m_pc[1:0] != 2'b00});
      chk({tag, " empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
      chk({tag, " full"}, {31'b0, ras_full}, {31'b0, m_ras.size() == 4});
   endtask

   initial begin
      // boot, push, all-at-once priority with flush
      tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h0040_0008, 0, 0, 0));
      tv.push_back(v(1, 1, 32'h1000, 1, 32'h8000_0180, 0, 0, 32'h8000_0180, 0, 1, 0));
      // call / redirect / return
      tv.push_back(v(0, 1, 32'h100, 0, 0, 0, 0, 32'h100, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h104, 0, 0, 0));
      tv.push_back(v(0, 1, 32'h2000, 0, 0, 0, 0, 32'h2000, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h2004, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 1, 0));
      // five pushes overflow a 4-deep stack
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h108, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h10C, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h110, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h114, 0, 0, 1));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h118, 0, 0, 1));
      tv.push_back(v(0, 1, 32'h3000, 0, 0, 0, 0, 32'h3000, 0, 0, 1));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h118, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h114, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h110, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h10C, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h110, 0, 1, 0));
      // pop-then-push, stalled call ignored
      tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h114, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h114, 0, 0, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h118, 0, 1, 0));
      tv.push_back(v(1, 0, 0, 0, 0, 1, 0, 32'h118, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h11C, 0, 1, 0));
      // wrap and misalignment
      tv.push_back(v(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 0));
      tv.push_back(v(0, 1, 32'h1002, 0, 0, 0, 0, 32'h1002, 1, 1, 0));
      tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h1006, 1, 1, 0));
      tv.push_back(v(0, 1, 32'h2000, 0, 0, 0, 0, 32'h2000, 0, 1, 0));

      model_reset();
      #12;
      chk("reset pc", cur_count, 32'h0);
      chk("reset valid", {31'b0, pc_valid}, 32'h0);
      chk("reset mis", {31'b0, misaligned}, 32'h0);
      chk("reset empty", {31'b0, ras_empty}, 32'h1);
      chk("reset full", {31'b0, ras_full}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].st, tv[i].rv, tv[i].ra, tv[i].ev, tv[i].ea, tv[i].cp, tv[i].rp);
         step();
         chk($sformatf("vec%0d pc", i), cur_count, tv[i].pc);
         chk($sformatf("vec%0d valid", i), {31'b0, pc_valid}, 32'h1);
         chk($sformatf("vec%0d mis", i), {31'b0, misaligned}, {31'b0, tv[i].mis});
         chk($sformatf("vec%0d empty", i), {31'b0, ras_empty}, {31'b0, tv[i].emp});
         chk($sformatf("vec%0d full", i), {31'b0, ras_full}, {31'b0, tv[i].ful});
      end

      for (int n = 0; n < 500; n++) begin
         drive($urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC),
               $urandom_range(0, 24) == 0,
               $urandom & 32'hFFFF_FFF0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0);
         step();
         chk_model($sformatf("rnd%0d", n));
      end

      // asynchronous reset while a stalled redirect is pending
      drive(0, 0, 0, 0, 0, 1, 0);
      step();
      @(negedge clock);
      drive(1, 1, 32'h5000, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async pc", cur_count, 32'h0);
      chk("async valid", {31'b0, pc_valid}, 32'h0);
      chk("async empty", {31'b0, ras_empty}, 32'h1);
      chk("async full", {31'b0, ras_full}, 32'h0);
      step();
      chk("held pc", cur_count, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      starting_addr = 32'h0080_0000;
      step();
      chk("reboot pc", cur_count, 32'h0080_0000);
      chk("reboot valid", {31'b0, pc_valid}, 32'h1);
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      chk_model("post");
      chk("post pc", cur_count, 32'h0080_0004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter INC, default 4, sequential increment in bytes.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-004 SHALL have parameter ALIGN_BITS, default 2, low PC bits that must be zero.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port starting_addr  in  ADDR_W  boot address, loaded once after reset.
REQ-008 SHALL have port stall  in  1  1 = hold PC (fetch stalled).
REQ-009 SHALL have port redirect_valid / redirect_addr  in  1 / ADDR_W  resolved branch/jump target.
REQ-010 SHALL have port exc_valid / exc_vector  in  1 / ADDR_W  exception entry address.
REQ-011 SHALL have port call_push  in  1  current instruction is a call; push cur_count+INC.
REQ-012 SHALL have port ret_pop  in  1  current instruction is a return; predict from stack top.
REQ-013 SHALL have port cur_count  out  ADDR_W  current fetch PC.
REQ-014 SHALL have ports pc_valid, misaligned, ras_empty, ras_full  out  1 each  status flags.

Function
REQ-015 SHALL implement states LOAD and RUN; reset forces LOAD.
REQ-016 In LOAD, the first posedge SHALL set cur_count=starting_addr, pc_valid=1, state=RUN; all other inputs ignored.
REQ-017 In RUN, next PC SHALL be chosen by priority: exc_valid > redirect_valid > stall (hold) > ret_pop with non-empty RAS (stack top) > cur_count+INC.
REQ-018 exc_valid and redirect_valid SHALL take effect even when stall=1 (never lost).
REQ-019 Latency: selected next PC SHALL appear on cur_count exactly one cycle after the selecting inputs.
REQ-020 cur_count+INC SHALL wrap modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0x00000000).
REQ-021 RAS push/pop SHALL occur only in a cycle where the PC advances sequentially or by pop (no exc, no redirect, no stall).
REQ-022 Simultaneous call_push and ret_pop SHALL pop-then-push: target=old top, top replaced by cur_count+INC, depth unchanged.
REQ-023 Push when full SHALL overwrite the oldest entry (circular); ras_full stays 1.
REQ-024 ret_pop when empty SHALL be ignored; PC increments normally.
REQ-025 exc_valid SHALL flush the RAS (depth 0) in the same cycle.
REQ-026 redirect_valid SHALL leave RAS contents untouched.
REQ-027 misaligned SHALL be registered alongside cur_count: 1 iff cur_count[ALIGN_BITS-1:0] != 0; PC still loaded as given.
REQ-028 ras_empty / ras_full SHALL reflect depth==0 / depth==RAS_DEPTH, registered.

Reset
REQ-029 Asserting reset SHALL immediately force cur_count=0, pc_valid=0, misaligned=0, RAS depth=0, ras_empty=1, ras_full=0, state=LOAD.
REQ-030 Reset asserted mid-operation SHALL abandon any pending redirect/exception; boot restarts via LOAD.

Structure
REQ-031 State encoding (LOAD/RUN) and next-PC select encoding SHALL live in a shared fetch package.
REQ-032 The RAS SHALL be a sub-module ras_stack (push, pop, top, empty, full, flush), parametrised by ADDR_W and RAS_DEPTH.

Verification
REQ-033 Boot: reset 1->0, starting_addr=0x00400000 -> cycle1 cur_count=0x00400000, pc_valid=1; cycle2 0x00400004.
REQ-034 Priority: stall=1, redirect 0x1000 and exc 0x80000180 same cycle -> cur_count=0x80000180, RAS flushed.
REQ-035 Call/return: at pc 0x100 call_push, redirect 0x2000, later ret_pop -> cur_count=0x104, ras_empty=1.
REQ-036 Overflow: 5 pushes with RAS_DEPTH=4 (values A..E) -> pops return E,D,C,B, then ras_empty=1, next pop increments.
REQ-037 Wrap/align: cur_count=0xFFFFFFFC increment -> 0x00000000; redirect 0x1002 -> misaligned=1.
REQ-038 Mid-run reset with stall=1 and redirect pending -> cur_count=0 asynchronously, then reload starting_addr.
